// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared width, rounding and saturation helpers for fir_stream
package fir_stream_pkg;

  // Accumulator wide enough that a full sum of TAPS products cannot overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Half an LSB of the output, added before the shift for round-half-up.
  function automatic int round_const(input int frac);
    return 1 << (frac - 1);
  endfunction

  // Largest representable output sample.
  function automatic int sat_max(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  // Smallest representable output sample.
  function automatic int sat_min(input int data_w);
    return -(1 << (data_w - 1));
  endfunction

endpackage

// File: rtl/fir_stream_round_sat.sv
// rtl/fir_stream_round_sat.sv - round, shift and narrow the accumulator; FIR_STREAM_SAT_EN selects clamp over wrap
module fir_stream_round_sat
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int FRAC   = 6
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_data
);

  localparam int                      SH_W   = ACC_W - FRAC;
  localparam logic signed [ACC_W-1:0] LP_RND = ACC_W'(round_const(FRAC));

  logic signed [ACC_W-1:0] w_rounded;
  logic signed [SH_W-1:0]  w_shifted;
  logic                    w_unused_frac;

  // The arithmetic shift right by FRAC is just dropping the fraction bits.
  assign w_rounded     = i_acc + LP_RND;
  assign w_shifted     = w_rounded[ACC_W-1:FRAC];
  assign w_unused_frac = ^w_rounded[FRAC-1:0];

`ifdef FIR_STREAM_SAT_EN
  localparam logic signed [SH_W-1:0] LP_MAX = SH_W'(sat_max(DATA_W));
  localparam logic signed [SH_W-1:0] LP_MIN = SH_W'(sat_min(DATA_W));

  // Clamp the shifted result into the output range.
  always_comb begin
    if (w_shifted > LP_MAX) begin
      o_data = LP_MAX[DATA_W-1:0];
    end else if (w_shifted < LP_MIN) begin
      o_data = LP_MIN[DATA_W-1:0];
    end else begin
      o_data = w_shifted[DATA_W-1:0];
    end
  end
`else
  logic w_unused_high;

  // Two's-complement wrap: keep only the low DATA_W bits.
  assign o_data        = w_shifted[DATA_W-1:0];
  assign w_unused_high = ^w_shifted[SH_W-1:DATA_W];
`endif

endmodule

// File: rtl/fir_stream.sv
// rtl/fir_stream.sv - streaming pipelined FIR with programmable taps; output narrowing set by FIR_STREAM_SAT_EN
module fir_stream
  import fir_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int FRAC   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data
);

  localparam int                       AW       = $clog2(TAPS);
  localparam int                       PROD_W   = DATA_W + COEF_W;
  localparam int                       ACC_W    = acc_width(DATA_W, COEF_W, TAPS);
  localparam logic signed [COEF_W-1:0] LP_UNITY = COEF_W'(1 << FRAC);

  logic signed [DATA_W-1:0] r_x    [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic signed [PROD_W-1:0] r_prod [TAPS];
  logic                     r_v0;
  logic                     r_v1;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_narrow;

  // Delay line: shift in a new sample only when one is offered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= in_valid;
      if (in_valid) begin
        r_x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
      end
    end
  end

  // Coefficient registers: reset to identity, out-of-range addresses match no tap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= (k == 0) ? LP_UNITY : '0;
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++) begin
        if ({1'b0, coef_addr} == (AW+1)'(k)) r_coef[k] <= coef_data;
      end
    end
  end

  // Product stage: uses coefficients as they stand at this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= r_v0;
      if (r_v0) begin
        for (int k = 0; k < TAPS; k++) begin
          r_prod[k] <= PROD_W'(r_coef[k]) * PROD_W'(r_x[k]);
        end
      end
    end
  end

  // Sum the sign-extended products at full accumulator width.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
  end

  fir_stream_round_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .FRAC   (FRAC)
  ) u_round_sat (
    .i_acc  (w_sum),
    .o_data (w_narrow)
  );

  // Output register: data only updates with a valid result, otherwise holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) r_out_data <= w_narrow;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_fir_stream.sv
// tb/tb_fir_stream.sv - directed self-checking bench for fir_stream (expects FIR_STREAM_SAT_EN as built)
module tb_fir_stream;

`ifdef FIR_STREAM_SAT_EN
  localparam logic signed [7:0] SAT_EXP = 8'sd127;
`else
  localparam logic signed [7:0] SAT_EXP = -8'sd4;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              out_valid5;
  logic signed [7:0] out_data5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_stream #(.DATA_W(8), .COEF_W(8), .TAPS(8), .FRAC(6)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Five-tap copy on the same stimulus: addresses 5..7 are out of range here.
  fir_stream #(.DATA_W(8), .COEF_W(8), .TAPS(5), .FRAC(6)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid5),
    .out_data  (out_data5)
  );

  task automatic step(input logic v, input logic signed [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic signed [7:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++;
    if (out_data !== 8'sd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", out_data); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'sd0);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid step %0d: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_identity;
    logic [0:5]        iv;
    logic [0:5]        ev;
    logic signed [7:0] id [6];
    logic signed [7:0] ed [6];
    iv = 6'b111100;
    ev = 6'b001111;
    id = '{8'sd10, -8'sd5, 8'sd127, 8'h80, 8'sd0, 8'sd0};
    ed = '{8'sd0, 8'sd0, 8'sd10, -8'sd5, 8'sd127, 8'h80};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(iv[i], id[i]);
      n_vec++;
      if (out_valid !== ev[i]) begin n_err++; $display("FAIL identity_valid step %0d: got %b want %b", i, out_valid, ev[i]); end
      if (ev[i]) begin
        n_vec++;
        if (out_data !== ed[i]) begin n_err++; $display("FAIL identity_data step %0d: got %0d want %0d", i, out_data, ed[i]); end
      end
    end
  endtask

  task automatic test_moving_average;
    logic signed [7:0] ed;
    apply_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'sd16);
    for (int i = 0; i < 12; i++) begin
      step(i < 10, (i == 0) ? 8'sd64 : 8'sd0);
      if (i >= 2) begin
        ed = (i < 10) ? 8'sd16 : 8'sd0;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL mavg_valid step %0d: got %b want 1", i, out_valid); end
        n_vec++;
        if (out_data !== ed) begin n_err++; $display("FAIL mavg_data step %0d: got %0d want %0d", i, out_data, ed); end
      end
    end
  endtask

  task automatic test_saturation;
    apply_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'sd127);
    step(1'b1, 8'sd127);
    step(1'b0, 8'sd0);
    step(1'b0, 8'sd0);
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", out_valid); end
    n_vec++;
    if (out_data !== SAT_EXP) begin n_err++; $display("FAIL sat_data: got %0d want %0d", out_data, SAT_EXP); end
  endtask

  task automatic test_neg_round;
    logic signed [7:0] id [4];
    logic signed [7:0] ed [4];
    id = '{-8'sd3, -8'sd33, 8'sd0, 8'sd0};
    ed = '{8'sd0, 8'sd0, 8'sd0, -8'sd1};
    apply_reset();
    write_coef(3'd0, 8'sd1);
    for (int i = 0; i < 4; i++) begin
      step(i < 2, id[i]);
      if (i >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL negrnd_valid step %0d: got %b want 1", i, out_valid); end
        n_vec++;
        if (out_data !== ed[i]) begin n_err++; $display("FAIL negrnd_data step %0d: got %0d want %0d", i, out_data, ed[i]); end
      end
    end
  endtask

  task automatic test_gapped;
    logic [0:6]        iv;
    logic [0:6]        ev;
    logic signed [7:0] id [7];
    logic [0:5]        iv2;
    logic [0:5]        ev2;
    logic signed [7:0] id2 [6];
    logic signed [7:0] ed2 [6];
    iv = 7'b1001100;
    ev = 7'b0010011;
    id = '{8'sd64, 8'sd99, 8'sd99, 8'sd64, 8'sd64, 8'sd0, 8'sd0};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(iv[i], id[i]);
      n_vec++;
      if (out_valid !== ev[i]) begin n_err++; $display("FAIL gap_valid step %0d: got %b want %b", i, out_valid, ev[i]); end
      if (ev[i]) begin
        n_vec++;
        if (out_data !== 8'sd64) begin n_err++; $display("FAIL gap_data step %0d: got %0d want 64", i, out_data); end
      end
    end
    // y = x[0] + x[1]: idle cycles must not push garbage into x[1].
    iv2 = 6'b100100;
    ev2 = 6'b001001;
    id2 = '{8'sd10, 8'sd99, 8'sd99, 8'sd20, 8'sd0, 8'sd0};
    ed2 = '{8'sd0, 8'sd0, 8'sd10, 8'sd0, 8'sd0, 8'sd30};
    apply_reset();
    write_coef(3'd1, 8'sd64);
    for (int i = 0; i < 6; i++) begin
      step(iv2[i], id2[i]);
      n_vec++;
      if (out_valid !== ev2[i]) begin n_err++; $display("FAIL gap2_valid step %0d: got %b want %b", i, out_valid, ev2[i]); end
      if (ev2[i]) begin
        n_vec++;
        if (out_data !== ed2[i]) begin n_err++; $display("FAIL gap2_data step %0d: got %0d want %0d", i, out_data, ed2[i]); end
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic signed [7:0] ed [4];
    ed = '{8'sd0, 8'sd0, 8'sd5, 8'sd7};
    apply_reset();
    write_coef(3'd0, 8'sd32);
    write_coef(3'd1, 8'sd64);
    step(1'b1, 8'sd100);
    step(1'b0, 8'sd0);
    step(1'b0, 8'sd0);
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
    n_vec++;
    if (out_data !== 8'sd50) begin n_err++; $display("FAIL pre_rst_data: got %0d want 50", out_data); end
    step(1'b1, 8'sd20);
    step(1'b1, 8'sd30);
    // Reset edge also carries a sample and a coefficient write; reset must win.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'sd40;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'sd1;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_vec++;
    if (out_data !== 8'sd0) begin n_err++; $display("FAIL mid_rst_data: got %0d want 0", out_data); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'sd0);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid step %0d: got %b want 0", i, out_valid); end
    end
    write_coef(3'd5, 8'h80);
    write_coef(3'd6, 8'h80);
    write_coef(3'd7, 8'h80);
    for (int i = 0; i < 4; i++) begin
      step(i < 2, (i == 0) ? 8'sd5 : 8'sd7);
      if (i >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL restored_valid step %0d: got %b want 1", i, out_valid); end
        n_vec++;
        if (out_data !== ed[i]) begin n_err++; $display("FAIL restored_data step %0d: got %0d want %0d", i, out_data, ed[i]); end
        n_vec++;
        if (out_valid5 !== 1'b1) begin n_err++; $display("FAIL oob_valid step %0d: got %b want 1", i, out_valid5); end
        n_vec++;
        if (out_data5 !== ed[i]) begin n_err++; $display("FAIL oob_data step %0d: got %0d want %0d", i, out_data5, ed[i]); end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = 3'd0;
    coef_data = 8'sd0;
    in_valid  = 1'b0;
    in_data   = 8'sd0;
    test_reset();
    test_identity();
    test_moving_average();
    test_saturation();
    test_neg_round();
    test_gapped();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_stream.md
# fir_stream

Parametrised, streaming, pipelined direct-form FIR filter with runtime-programmable coefficients and a valid handshake. It succeeds the fixed 8-bit `fir` core and is used wherever sample streams arrive with gaps or need reloadable taps. The filter computes a signed sum of products, then rounds, shifts and narrows the result back to the input width. Output follows each accepted sample by a fixed 2-cycle latency.

## Interface
- `DATA_W`, 8: signed sample width (in and out).
- `COEF_W`, 8: signed coefficient width.
- `TAPS`, 8: number of taps, ≥2.
- `FRAC`, 6: fractional bits of coefficients; 1 ≤ FRAC ≤ COEF_W-2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk`).
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(TAPS)  tap index to write.
- `coef_data`  in  COEF_W  signed coefficient value.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_data`  in  DATA_W  signed input sample.
- `out_valid`  out  1  `out_data` valid, one-cycle pulse per sample.
- `out_data`  out  DATA_W  signed filtered sample.

## Operation
- Delay line `x[0..TAPS-1]`, `x[0]` newest. It shifts only on edges with `in_valid=1`. No `in_valid` means no shift and no output.
- The filter computes y = Σ c[k]·x[k]. The accumulator width is ACC_W = DATA_W+COEF_W+$clog2(TAPS), so no internal overflow is possible.
- Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
- Narrowing: see Configuration.
- Coefficient write: on an edge with `coef_we=1` and `coef_addr<TAPS`, `c[coef_addr]` ← `coef_data`. Writes with `coef_addr≥TAPS` are ignored.
- Writes are allowed while samples are in flight. The product stage always uses the coefficient registers as they stand at its edge. A sample accepted on the same edge as a write therefore uses the new coefficient.
- Reset values:
  - `out_valid`=0 and `out_data`=0.
  - All `x`=0.
  - Pipeline valid bits=0.
  - `c[0]`=2^FRAC and all other `c`=0, giving the identity filter.
- Reset mid-stream discards in-flight samples. No `out_valid` is raised for them.

## Timing
- Edge E0: `in_valid` sampled and delay line shifted.
- Edge E1: TAPS products registered, with stage valid v1.
- Edge E2: adder tree, round and narrow; `out_data`/`out_valid` registered.
- Latency: `out_valid` is high in the cycle after E2, i.e. 2 cycles after the cycle in which `in_valid` was high.
- Throughput: one sample per cycle. Back-to-back valids give back-to-back `out_valid`.
- `out_data` holds its last value while `out_valid`=0.
- Reset takes priority over `coef_we` and `in_valid` on the same edge.

## Configuration
- Macro: `FIR_STREAM_SAT_EN`.
- Defined: the rounded result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the result is truncated to its low DATA_W bits (two's-complement wrap).

## Structure
- Package `fir_stream_pkg` holds:
  - the ACC_W computation function;
  - the rounding-constant function;
  - the saturation limit constants, as functions of DATA_W.
- Sub-module `fir_stream_round_sat` is combinational. It takes ACC_W in and produces DATA_W out, covering the round, shift and saturate/wrap step, with the macro test contained inside it.
- The top level holds the delay line, the coefficient registers, the product stage, the adder tree and the valid pipeline.

## Test plan
- Identity after reset. Drive 10, -5, 127, -128 back-to-back; expect `out_data` 10, -5, 127, -128 with `out_valid` exactly 2 cycles after each input.
- Moving average, TAPS=8. Write all c=16, then send an impulse of 64 followed by zeros; expect 16 for eight consecutive outputs, then 0.
- Saturation vs wrap. Write all c=127 and drive x=127 once; the first output is (16129+32)>>6 = 252. Expect 127 with `FIR_STREAM_SAT_EN` defined and -4 without it.
- Negative rounding. Write c[0]=1 and drive -3 and -33; expect 0 and -1.
- Gapped input. Drive `in_valid` as 1,0,0,1,1 with data 64,x,x,64,64 under identity; expect exactly three `out_valid` pulses, each 2 cycles after its input, values 64, 64, 64. The delay line must not shift on idle cycles.
- Reset mid-stream. Assert `reset`=0 one cycle after two valid samples; expect no `out_valid`, `out_data`=0, and coefficients restored to identity. A write to `coef_addr`=TAPS is ignored.
